// File: rtl/dcache_miss_handler.sv
// Data-cache miss engine: victim selection, optional dirty-line writeback,
// then a four-chunk line fill from main memory.
module dcache_miss_handler #(
    parameter int TAG_SIZE   = 18,
    parameter int INDEX_SIZE = 8,
    parameter int CHUNK_W    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic [31:0]           miss_addr,
    output logic                  miss_ready,
    output logic                  miss_done,
    output logic                  cache_w_tagcheck,
    output logic                  cache_w,
    output logic [INDEX_SIZE-1:0] cache_w_index,
    output logic [TAG_SIZE-1:0]   cache_w_tag,
    output logic [5:0]            cache_w_line,
    output logic [1:0]            cache_w_way,
    output logic [CHUNK_W-1:0]    cache_w_data,
    output logic                  cache_r,
    output logic [INDEX_SIZE-1:0] cache_r_index,
    output logic [5:0]            cache_r_line,
    input  logic [1:0]            cache_way,
    input  logic                  cache_dirty,
    input  logic [TAG_SIZE-1:0]   cache_tag_out,
    input  logic [CHUNK_W-1:0]    cache_data_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [CHUNK_W-1:0]    mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [CHUNK_W-1:0]    mem_rdata
);

    typedef enum logic [3:0] {
        IDLE,
        TAGCHK,
        TAGCAP,
        WB_RD,
        WB_CAP,
        WB_REQ,
        FILL_REQ,
        FILL_WAIT,
        FILL_WR,
        DONE
    } state_t;

    state_t                state, state_nx;
    logic [TAG_SIZE-1:0]   miss_tag;
    logic [TAG_SIZE-1:0]   victim_tag;
    logic [INDEX_SIZE-1:0] index;
    logic [1:0]            chunk;
    logic [1:0]            victim_way;
    logic [CHUNK_W-1:0]    wb_buf;
    logic [CHUNK_W-1:0]    fill_buf;

    // Byte-within-line bits never matter: the whole line is transferred.
    logic unused_offset_bits;
    assign unused_offset_bits = ^miss_addr[5:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            chunk      <= '0;
            miss_tag   <= '0;
            victim_tag <= '0;
            index      <= '0;
            victim_way <= '0;
            wb_buf     <= '0;
            fill_buf   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        miss_tag <= miss_addr[31 -: TAG_SIZE];
                        index    <= miss_addr[6 +: INDEX_SIZE];
                        chunk    <= '0;
                    end
                end
                TAGCAP: begin
                    victim_way <= cache_way;
                    victim_tag <= cache_tag_out;
                end
                WB_CAP: wb_buf <= cache_data_out;
                // The 2-bit counter wraps 3->0 here, ready for the fill.
                WB_REQ: begin
                    if (mem_ready) chunk <= chunk + 2'd1;
                end
                FILL_WAIT: begin
                    if (mem_rvalid) fill_buf <= mem_rdata;
                end
                FILL_WR: begin
                    if (chunk != 2'd3) chunk <= chunk + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx         = state;
        miss_ready       = 1'b0;
        miss_done        = 1'b0;
        cache_w_tagcheck = 1'b0;
        cache_w          = 1'b0;
        cache_w_index    = '0;
        cache_w_tag      = '0;
        cache_w_line     = '0;
        cache_w_way      = '0;
        cache_w_data     = '0;
        cache_r          = 1'b0;
        cache_r_index    = '0;
        cache_r_line     = '0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_req) state_nx = TAGCHK;
            end
            TAGCHK: begin
                cache_w_tagcheck = 1'b1;
                cache_w_index    = index;
                cache_w_tag      = miss_tag;
                state_nx         = TAGCAP;
            end
            TAGCAP: state_nx = cache_dirty ? WB_RD : FILL_REQ;
            WB_RD: begin
                cache_r       = 1'b1;
                cache_r_index = index;
                cache_r_line  = {chunk, 4'b0000};
                state_nx      = WB_CAP;
            end
            WB_CAP: state_nx = WB_REQ;
            WB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {victim_tag, index, chunk, 4'b0000};
                mem_wdata = wb_buf;
                if (mem_ready) state_nx = (chunk == 2'd3) ? FILL_REQ : WB_RD;
            end
            FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag, index, chunk, 4'b0000};
                if (mem_ready) state_nx = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_rvalid) state_nx = FILL_WR;
            end
            FILL_WR: begin
                cache_w       = 1'b1;
                cache_w_index = index;
                cache_w_tag   = miss_tag;
                cache_w_way   = victim_way;
                cache_w_line  = {chunk, 4'b0000};
                cache_w_data  = fill_buf;
                state_nx      = (chunk == 2'd3) ? DONE : FILL_REQ;
            end
            DONE: begin
                miss_done = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/dcache_miss_handler.md
# dcache_miss_handler

Memory-side miss engine for the data cache. On a pipeline miss it runs a tag-check to pick the victim way. If the victim is dirty, it reads the victim line out of the cache and writes it to main memory in four 128-bit chunks. It then fetches the missing line from memory in four chunks and writes it into the cache, finally pulsing completion back to the pipeline. It drives the cache's write/tag-check/read ports and consumes the cache's `tag_out`/`data_out`/`way`/`dirty` outputs.

## Interface
Parameters:
- TAG_SIZE, 18, tag bits (addr[31:14])
- INDEX_SIZE, 8, set index bits (addr[13:6])
- CHUNK_W, 128, bits per chunk; a line is 4 chunks (64 B)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- miss_req  in  1  pipeline miss request, sampled when miss_ready=1
- miss_addr  in  32  missing byte address
- miss_ready  out  1  engine idle, can accept a request
- miss_done  out  1  one-cycle pulse: line installed
- cache_w_tagcheck  out  1  victim-selection read strobe to cache
- cache_w  out  1  cache chunk write strobe
- cache_w_index  out  8  set for tag-check/fill
- cache_w_tag  out  18  tag for tag-check/fill
- cache_w_line  out  6  chunk offset; {chunk,4'b0}
- cache_w_way  out  2  way being filled
- cache_w_data  out  128  fill data
- cache_r  out  1  cache read strobe (victim readout)
- cache_r_index  out  8  victim set
- cache_r_line  out  6  victim chunk offset
- cache_way  in  2  victim way, valid the cycle after cache_w_tagcheck
- cache_dirty  in  1  victim dirty, same timing
- cache_tag_out  in  18  victim tag, same timing
- cache_data_out  in  128  chunk data, valid the cycle after cache_r
- mem_req  out  1  memory request valid
- mem_we  out  1  1=write chunk, 0=read chunk
- mem_addr  out  32  chunk-aligned address ([3:0]=0)
- mem_wdata  out  128  writeback data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  128  read data

## Operation
- States: IDLE, TAGCHK, TAGCAP, WB_RD, WB_CAP, WB_REQ, FILL_REQ, FILL_WAIT, FILL_WR, DONE.
- IDLE: miss_ready=1. On miss_req, latch tag/index from miss_addr and clear the 2-bit chunk counter. Go to TAGCHK.
- TAGCHK: assert cache_w_tagcheck for one cycle with latched index/tag. Go to TAGCAP.
- TAGCAP: latch cache_way, cache_dirty, cache_tag_out. If dirty, go to WB_RD; otherwise go to FILL_REQ.
- WB_RD: assert cache_r with r_index=index and r_line={chunk,4'b0}. Go to WB_CAP.
- WB_CAP: latch cache_data_out into the writeback buffer. Go to WB_REQ.
- WB_REQ: mem_req=1, mem_we=1, mem_addr={victim_tag,index,chunk,4'b0}, mem_wdata=buffer. Hold all of these until mem_ready.
  - On accept with chunk=3: reset chunk to 0 and go to FILL_REQ.
  - Otherwise: increment chunk and go to WB_RD.
- FILL_REQ: mem_req=1, mem_we=0, mem_addr={miss_tag,index,chunk,4'b0}. Hold until mem_ready, then go to FILL_WAIT.
- FILL_WAIT: on mem_rvalid, latch mem_rdata and go to FILL_WR. Wait indefinitely otherwise.
- FILL_WR: cache_w=1 with w_index=index, w_tag=miss_tag, w_way=victim way, w_line={chunk,4'b0}, w_data=latched data.
  - If chunk=3, go to DONE.
  - Otherwise increment chunk and go to FILL_REQ.
- DONE: miss_done=1 for one cycle. Go to IDLE.
- Only one memory transaction is outstanding at a time. Chunks are processed in order 0..3. The chunk counter wraps 3→0 only on the writeback-to-fill transition.

## Timing
- Reset: state=IDLE, chunk=0. All strobes (cache_w, cache_w_tagcheck, cache_r, mem_req, mem_we, miss_done) are 0. All address/data outputs are 0. miss_ready=1 in the first cycle after reset.
- Reset mid-operation: the engine aborts to IDLE next cycle with no further strobes. A late mem_rvalid after reset is ignored.
- miss_req while miss_ready=0 is ignored and not queued.
- mem_rvalid outside FILL_WAIT is ignored.
- Clean miss, with memory ready and rvalid one cycle after accept: miss_req at cycle 0, then tagcheck at cycle 1, and miss_done at cycle 15.
- Dirty miss, same memory timing: adds 12 cycles (4 × WB_RD/WB_CAP/WB_REQ), so miss_done is at cycle 27.
- Each mem_ready stall adds one cycle per stalled cycle. mem_req outputs are stable while stalled.
- Outputs are registered (Moore); none depend combinationally on inputs.

## Test plan
- Clean miss: addr 0x1234_5680, cache_dirty=0, cache_way=2. Expect:
  - four mem reads at 0x12345680/90/A0/B0;
  - four cache_w with w_way=2, w_index=0x5A, w_tag=0x048D1, w_line=0x00/0x10/0x20/0x30;
  - miss_done at cycle 15;
  - no mem_we=1.
- Dirty miss: cache_dirty=1, cache_tag_out=0x3FFFF, index 0x01. Expect:
  - four writes at 0xFFFFC040..0xFFFFC070 whose mem_wdata equals the chunk data returned per cache_r;
  - then four fills;
  - miss_done at cycle 27.
- Backpressure: hold mem_ready=0 for 5 cycles on each request. Expect mem_req/mem_addr/mem_wdata stable throughout, and completion delayed by exactly 5 × (number of requests).
- Busy/spurious: assert miss_req during FILL_WAIT and pulse mem_rvalid during WB_REQ. Expect the request to be ignored, no state change, and miss_ready=0 until after DONE.
- Reset mid-writeback: assert rst during chunk 2 WB_REQ. Expect IDLE next cycle, all strobes 0, miss_ready=1. A following clean miss completes normally.
- Back-to-back: issue a second miss_req the cycle miss_ready returns. Expect it to be accepted and the chunk counter to restart at 0.
